// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Drives an 8-digit multiplexed seven-segment display. A 16-bit binary value
//   is accepted over a load/ready handshake and converted to 5 BCD digits by a
//   sequential double-dabble engine. All 5 digits are committed in one cycle,
//   so the display never shows a partial conversion. A free-running scan
//   scheduler presents one digit at a time on digit_sel/digit_code. An
//   optional blank gap tick can be inserted between digits, and leading zeros
//   can be suppressed.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   data       binary value to display, sampled only in the accept cycle
//   load       request; accepted when load && ready
//   ready      converter idle
//   digit_sel  one-hot digit enable, bit0 = least-significant digit, 0 in a gap
//   digit_code 0..9 for a digit, 5'h10 for blank (feeds hex_seg7)
//   conv_done  one-cycle pulse while new digits are being committed
//
// Converter states
//   state  | meaning
//   IDLE   | ready, waiting for load
//   CONV   | 16 double-dabble iterations, bit_cnt 15 -> 0
//   COMMIT | copy BCD to display digits, pulse conv_done
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter bit          GAP_EN      = 1'b1,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        load,
  output logic        ready,
  output logic [7:0]  digit_sel,
  output logic [4:0]  digit_code,
  output logic        conv_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [4:0] BLANK = 5'h10;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;

  conv_state_t state, state_next;

  logic [15:0] shift_reg;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  bit_cnt;
  logic [19:0] digits;

  logic [PW-1:0] presc;
  logic          tick;
  logic [2:0]    scan_idx;
  logic          gap;
  logic [4:0]    drive_code;
  logic [4:0]    lz_blank;

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (bit_cnt == 4'd0) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    conv_done = (state == COMMIT);
  end

  // Add-3 correction per nibble, no carry between nibbles.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      digits    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= data;
            bcd       <= '0;
            bit_cnt   <= 4'd15;
          end
        end
        CONV: begin
          {bcd, shift_reg} <= {bcd_adj[18:0], shift_reg, 1'b0};
          bit_cnt          <= bit_cnt - 4'd1;
        end
        COMMIT:  digits <= bcd;
        default: ;
      endcase
    end
  end

  // ---------------- scan scheduler ----------------
  assign tick = (presc == PW'(SCAN_DIV - 1));

  // lz_blank[i]: digit i and every higher digit up to 4 are zero.
  always_comb begin
    lz_blank    = '0;
    lz_blank[4] = (digits[19:16] == 4'd0);
    for (int i = 3; i >= 0; i--) begin
      lz_blank[i] = lz_blank[i+1] && (digits[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    drive_code = BLANK;
    case (scan_idx)
      3'd0: drive_code = {1'b0, digits[3:0]};
      3'd1: drive_code = (LZ_SUPPRESS && lz_blank[1]) ? BLANK : {1'b0, digits[7:4]};
      3'd2: drive_code = (LZ_SUPPRESS && lz_blank[2]) ? BLANK : {1'b0, digits[11:8]};
      3'd3: drive_code = (LZ_SUPPRESS && lz_blank[3]) ? BLANK : {1'b0, digits[15:12]};
      3'd4: drive_code = (LZ_SUPPRESS && lz_blank[4]) ? BLANK : {1'b0, digits[19:16]};
      default: drive_code = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      scan_idx   <= '0;
      gap        <= 1'b0;
      digit_sel  <= 8'h00;
      digit_code <= BLANK;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (GAP_EN && gap) begin
          digit_sel  <= 8'h00;
          digit_code <= BLANK;
          gap        <= 1'b0;
          scan_idx   <= scan_idx + 3'd1;
        end else begin
          digit_sel  <= 8'd1 << scan_idx;
          digit_code <= drive_code;
          if (GAP_EN) gap <= 1'b1;
          else        scan_idx <= scan_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;

  logic       ready_a, ready_b, ready_c;
  logic       done_a, done_b, done_c;
  logic [7:0] sel_a, sel_b, sel_c;
  logic [4:0] code_a, code_b, code_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: LZ on, no gap. B: LZ off, no gap. C: LZ on, gap, fast scan.
  seg_scan_ctrl #(.SCAN_DIV(4), .GAP_EN(1'b0), .LZ_SUPPRESS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .data(data), .load(load), .ready(ready_a),
    .digit_sel(sel_a), .digit_code(code_a), .conv_done(done_a));
  seg_scan_ctrl #(.SCAN_DIV(4), .GAP_EN(1'b0), .LZ_SUPPRESS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .data(data), .load(load), .ready(ready_b),
    .digit_sel(sel_b), .digit_code(code_b), .conv_done(done_b));
  seg_scan_ctrl #(.SCAN_DIV(2), .GAP_EN(1'b1), .LZ_SUPPRESS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .data(data), .load(load), .ready(ready_c),
    .digit_sel(sel_c), .digit_code(code_c), .conv_done(done_c));

  typedef struct {
    logic [15:0] value;
    logic [24:0] codes_lz;  // {d4,d3,d2,d1,d0} expected with LZ on
    logic [24:0] codes_nolz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready_a", ready_a, 1);  chk("rst_done_a", done_a, 0);
    chk("rst_sel_a", sel_a, 0);      chk("rst_code_a", code_a, 5'h10);
    chk("rst_ready_b", ready_b, 1);  chk("rst_sel_b", sel_b, 0);
    chk("rst_code_b", code_b, 5'h10);
    chk("rst_ready_c", ready_c, 1);  chk("rst_sel_c", sel_c, 0);
    chk("rst_code_c", code_c, 5'h10); chk("rst_done_c", done_c, 0);
  endtask

  // Called right after rst is released on a negedge; checks exact scan timing
  // with all-zero committed digits.
  task automatic after_reset();
    logic [7:0] es;
    logic [4:0] ea, eb;
    int idx, m;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n < 4) begin
        es = 8'h00; ea = 5'h10; eb = 5'h10;
      end else begin
        idx = ((n / 4) - 1) % 8;
        es = 8'd1 << idx;
        ea = (idx == 0) ? 5'd0 : 5'h10;
        eb = (idx < 5) ? 5'd0 : 5'h10;
      end
      chk("scan_sel_a", sel_a, es);
      chk("scan_code_a", code_a, ea);
      chk("scan_sel_b", sel_b, es);
      chk("scan_code_b", code_b, eb);
      m = n / 2;
      if (m == 0 || (m % 2) == 0) begin
        es = 8'h00; ea = 5'h10;
      end else begin
        idx = ((m - 1) / 2) % 8;
        es = 8'd1 << idx;
        ea = (idx == 0) ? 5'd0 : 5'h10;
      end
      chk("gap_sel_c", sel_c, es);
      chk("gap_code_c", code_c, ea);
      chk("idle_ready", ready_a, 1);
      chk("idle_no_done", done_a, 0);
    end
  endtask

  task automatic do_conv(input logic [15:0] d);
    @(negedge clk);
    chk("pre_ready", ready_a, 1);
    load = 1'b1;
    data = d;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin
        load = 1'b0;
        data = ~d;  // must not affect the conversion
        chk("busy_ready", ready_a, 0);
      end
      if (k == 16) chk("early_done", done_a, 0);
      if (k == 17) begin
        chk("done_n17", done_a, 1);
        chk("ready_n17", ready_a, 0);
      end
      if (k == 18) begin
        chk("ready_n18", ready_a, 1);
        chk("done_n18", done_a, 0);
      end
    end
  endtask

  task automatic capture(output logic [39:0] fa, output logic [39:0] fb,
                         output logic [39:0] fc);
    fa = '1; fb = '1; fc = '1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (sel_a == (8'd1 << i)) fa[5*i +: 5] = code_a;
        if (sel_b == (8'd1 << i)) fb[5*i +: 5] = code_b;
        if (sel_c == (8'd1 << i)) fc[5*i +: 5] = code_c;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] fa, fb, fc;
    logic [24:0] exp100;

    vecs[0] = '{16'd1234,  {5'h10, 5'd1, 5'd2, 5'd3, 5'd4}, {5'd0, 5'd1, 5'd2, 5'd3, 5'd4}};
    vecs[1] = '{16'd65535, {5'd6, 5'd5, 5'd5, 5'd3, 5'd5},  {5'd6, 5'd5, 5'd5, 5'd3, 5'd5}};
    vecs[2] = '{16'd0,     {5'h10, 5'h10, 5'h10, 5'h10, 5'd0}, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    vecs[3] = '{16'd7,     {5'h10, 5'h10, 5'h10, 5'h10, 5'd7}, {5'd0, 5'd0, 5'd0, 5'd0, 5'd7}};
    vecs[4] = '{16'd100,   {5'h10, 5'h10, 5'd1, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd1, 5'd0, 5'd0}};
    vecs[5] = '{16'd10005, {5'd1, 5'd0, 5'd0, 5'd0, 5'd5},   {5'd1, 5'd0, 5'd0, 5'd0, 5'd5}};
    vecs[6] = '{16'd40960, {5'd4, 5'd0, 5'd9, 5'd6, 5'd0},   {5'd4, 5'd0, 5'd9, 5'd6, 5'd0}};
    vecs[7] = '{16'd9,     {5'h10, 5'h10, 5'h10, 5'h10, 5'd9}, {5'd0, 5'd0, 5'd0, 5'd0, 5'd9}};
    exp100  = {5'h10, 5'h10, 5'd1, 5'd0, 5'd0};

    // Reset state and free-running scan with zero digits.
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    after_reset();

    // Conversions and full-frame checks.
    for (int v = 0; v < 8; v++) begin
      do_conv(vecs[v].value);
      capture(fa, fb, fc);
      chk($sformatf("frame_lz_%0d", vecs[v].value), fa, {15'h4210, vecs[v].codes_lz});
      chk($sformatf("frame_nolz_%0d", vecs[v].value), fb, {15'h4210, vecs[v].codes_nolz});
      chk($sformatf("frame_gap_%0d", vecs[v].value), fc, {15'h4210, vecs[v].codes_lz});
    end

    // load held high; data changes mid-conversion; re-trigger on next ready.
    @(negedge clk);
    load = 1'b1;
    data = 16'd100;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 5) data = 16'd999;
      if (k == 19) load = 1'b0;
      if (k == 17) chk("hold_done1", done_a, 1);
      if (k == 18) chk("hold_ready", ready_a, 1);
      if (k == 19) chk("hold_busy2", ready_a, 0);
      if (k == 34) chk("hold_early2", done_a, 0);
      if (k == 35) chk("hold_done2", done_a, 1);
      if (k == 36) chk("hold_ready2", ready_a, 1);
      if (k >= 19 && k <= 35) begin
        for (int i = 0; i < 5; i++)
          if (sel_a == (8'd1 << i)) chk("hold_show100", code_a, exp100[5*i +: 5]);
      end
    end
    capture(fa, fb, fc);
    chk("frame_999_lz", fa, {15'h4210, 5'h10, 5'h10, 5'd9, 5'd9, 5'd9});
    chk("frame_999_nolz", fb, {15'h4210, 5'd0, 5'd0, 5'd9, 5'd9, 5'd9});
    chk("no_retrigger", ready_a, 1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    load = 1'b1;
    data = 16'd4321;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
    end
    chk("mid_busy", ready_a, 0);
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    after_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Controller for the 8-digit multiplexed seven-segment display path.
- Accepts a 16-bit binary value through a valid/ready handshake.
- Converts the value to 5 BCD digits with a sequential double-dabble engine, then commits all digits at once.
- Time-multiplexes the digits onto one-hot digit selects and a 5-bit code bus that feeds the existing hex_seg7 decoder. Code 5'h10 is the blank symbol.

Parameters:
SCAN_DIV, 1000, clk cycles per scan tick (minimum 2).
GAP_EN, 1, when 1, insert one blank tick between digits (anti-ghosting).
LZ_SUPPRESS, 1, when 1, blank leading zeros of the 5-digit value; digit 0 is always shown.

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  asynchronous reset, active-high
data  in  16  binary value to display (0..65535)
load  in  1  request; accepted in a cycle where load && ready
ready  out  1  high when the converter is idle and can accept a value
digit_sel  out  8  one-hot digit enable; bit0 = least-significant digit; all zero during a blank gap
digit_code  out  5  code to hex_seg7: 0..9 for a digit, 5'h10 for blank
conv_done  out  1  one-cycle pulse when new digits are committed

Behaviour:
Reset (async, while rst=1):
- ready=1, conv_done=0, digit_sel=8'h00, digit_code=5'h10.
- Committed digits all 0. Scan index 0, prescaler 0, gap flag 0, converter IDLE.

Converter FSM: IDLE -> CONV -> COMMIT -> IDLE.
- IDLE: ready=1. When load=1, latch data into the shift register, clear the 20-bit BCD register, set bit counter to 15, go to CONV. ready drops the next cycle.
- CONV, 16 cycles: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,shift} left by 1. After the cycle with counter = 0, go to COMMIT.
- COMMIT, 1 cycle: copy the 5 BCD nibbles to the committed digit registers, pulse conv_done=1, go to IDLE.
- Latency: load accepted at cycle N; conv_done and new digits visible at cycle N+17; ready=1 again at N+18.
- load while ready=0 is ignored and not queued. load held high re-triggers on every ready window.
- data is sampled only in the accept cycle; later changes have no effect on the conversion in progress.
- Committed digits change only in COMMIT, so the display never shows a partial conversion.

Scan scheduler (free-running, independent of the converter):
- Prescaler counts 0..SCAN_DIV-1. A tick occurs on the wrap.
- GAP_EN=0: on each tick, scan index advances 0..7 and wraps 7 -> 0.
- GAP_EN=1: ticks alternate between drive and gap. The index advances after each gap, so a full frame is 16 ticks.
- Outputs are registered and update in the tick cycle.
- Drive, index i: digit_sel = 1<<i.
  - i = 0..4: digit_code = committed digit i.
  - i = 5..7: digit_code = 5'h10.
- Gap: digit_sel = 0, digit_code = 5'h10.
- Leading-zero suppression (LZ_SUPPRESS=1): digit i (1..4) shows 5'h10 if it and all higher digits 4..i are zero. digit_sel still asserts for that position.
- A COMMIT in the same cycle as a tick: the tick uses the old digits; new digits take effect from the next tick.
- rst asserted mid-conversion or mid-scan: immediately returns to the reset values above; the conversion is discarded.

Widths:
- BCD register is 20 bits (5 nibbles); max value 65535 gives digits 6,5,5,3,5.
- The add-3 correction is applied per nibble before the shift, with no carry between nibbles.

Test Plan:
1. Reset, SCAN_DIV=4, GAP_EN=0, no load -> digit_sel steps 01,02,...,80,01 every 4 clocks. Codes are 0,10h,10h,10h,10h,10h,10h,10h (LZ on).
2. load data=16'd1234 at cycle N -> ready=0 from N+1; conv_done pulse at N+17; frame shows codes 4,3,2,1,10h,10h,10h,10h; ready=1 at N+18.
3. data=65535 -> digits 5,3,5,5,6. data=0 -> digit 0 shows 0, digits 1..7 blank. LZ_SUPPRESS=0, data=7 -> codes 7,0,0,0,0,10h,10h,10h.
4. load=1 held with data=100, then data changed to 999 at N+5 -> displays 100. A second conversion starts at N+18 and commits 999 at N+35.
5. GAP_EN=1, SCAN_DIV=2 -> digit_sel pattern 01,00,02,00,... with the blank code during gaps; frame length 32 clocks.
6. rst pulsed at N+8 of a conversion of 4321 -> all outputs return to reset values and ready=1. The displayed digits stay at their previous reset value 0; no conv_done pulse.
